div_ip_arbiter: RTL and testbench
=================================

# div_ip_arbiter

Shares one instance of the team's combinational divider IP between two requesters, with a round-robin grant. The block latches the granted operands and holds them stable on the divider for a programmable number of cycles, which covers the divider's multicycle path. It then registers the quotient and presents it on a single result port with valid/ready backpressure. It sits between the two compute engines and the single DIV_IP macro.

## Interface
- IP_WIDTH, 7: number of 4-bit digits; operand and quotient width is IP_WIDTH*4.
- CALC_CYCLES, 1: cycles operands are held on the divider before the quotient is captured; legal range 1..15.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid0 / in_valid1  in  1  requester k has an operation pending.
- in_ready0 / in_ready1  out  1  requester k granted; transfer when in_valid_k && in_ready_k at an edge.
- dividend0 / dividend1  in  IP_WIDTH*4  unsigned dividend of requester k.
- divisor0 / divisor1  in  IP_WIDTH*4  unsigned divisor of requester k.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_id  out  1  requester index that owns the result.
- out_quotient  out  IP_WIDTH*4  floor(dividend/divisor), unsigned.
- out_dz  out  1  divisor was zero.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - CALC: operands held on the divider; cycle counter running.
  - DONE: result held until consumed.
- Grant in IDLE, combinational from valids:
  - Only one requester valid: that one is granted.
  - Both valid: grant = ~last_grant.
  - in_ready_k = (state==IDLE) && grant==k; both in_ready are 0 outside IDLE.
- On transfer:
  - dividend, divisor and id are latched into operand registers.
  - last_grant <= id, cnt <= 0, state -> CALC.
  - Requester may change its inputs from the next cycle.
- CALC:
  - Operand registers drive the divider; cnt increments each cycle.
  - At the edge where cnt == CALC_CYCLES-1: out_quotient <= divider output, out_dz <= (divisor==0), out_id <= id, out_valid <= 1, state -> DONE.
- Divisor zero: out_quotient is forced to all ones (IP output ignored) and out_dz=1. It still takes the full CALC_CYCLES.
- DONE:
  - out_valid, out_id, out_quotient and out_dz are held stable while out_ready=0.
  - At an edge with out_ready=1: out_valid <= 0, state -> IDLE.
  - No new request is accepted in the same cycle as the result handshake.
- Only one operation is in flight; no queueing.

## Timing
- Reset (asynchronous, any state): state=IDLE, out_valid=0, out_id=0, out_quotient=0, out_dz=0, last_grant=1 (requester 0 wins the first tie), cnt=0, operand registers=0.
- A reset mid-CALC or mid-DONE discards the operation; no result is emitted.
- Latency: transfer at edge T; out_valid rises after edge T+CALC_CYCLES.
- Earliest next transfer: edge after the out_ready handshake.
- Minimum issue interval: CALC_CYCLES+2 cycles with out_ready tied high.
- in_ready may depend combinationally on in_valid of the same cycle; no combinational path exists from out_ready to in_ready.
- A requester's valid falling before grant is legal; no request is latched.

## Structure
- Shared package div_arb_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - CNT_W=4.
  - Default IP_WIDTH=7.
- One sub-module: the DIV_IP instance (parameter IP_WIDTH), fed only from the operand registers.
- Grant logic, FSM and counter are inline.

## Test plan
IP_WIDTH=7, CALC_CYCLES=1 unless stated.
- **Single request:** req0 100/7 at edge T, out_ready=1 -> out_valid after T+1, out_quotient=14, out_id=0, out_dz=0; out_valid low after T+2.
- **Simultaneous after reset:** req0 50/5, req1 81/9 held valid -> first result id 0, quotient 10; second result id 1, quotient 9.
- **Continuous contention:** both valid for 8 operations -> out_id sequence 0,1,0,1,0,1,0,1; issue interval 3 cycles.
- **Divide by zero:** req1 0xFFFFFFF/0 -> out_quotient=0xFFFFFFF, out_dz=1, out_id=1.
- **Backpressure:** out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready0=in_ready1=0 throughout. With CALC_CYCLES=3, latency is 3 cycles.
- **Reset mid-CALC:** rst_n low one cycle during CALC -> all outputs at reset values, no result emitted. Next tie grants req0.

Source files
------------

// File: rtl/div_arb_pkg.sv
// Shared constants and state encoding for the divider arbiter and its DIV_IP wrapper.
package div_arb_pkg;

    localparam int DEF_IP_WIDTH = 7;
    localparam int CNT_W        = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/div_ip_arbiter_div.sv
// Combinational DIV_IP macro: unsigned quotient of IP_WIDTH 4-bit digits.
module div_ip
    import div_arb_pkg::*;
#(
    parameter int IP_WIDTH = DEF_IP_WIDTH
) (
    input  logic [IP_WIDTH*4-1:0] dividend,
    input  logic [IP_WIDTH*4-1:0] divisor,
    output logic [IP_WIDTH*4-1:0] quotient
);

    // Zero divisor yields all ones so the output is never X in simulation.
    assign quotient = (divisor == '0) ? '1 : dividend / divisor;

endmodule

// File: rtl/div_ip_arbiter.sv
// Round-robin arbiter sharing one multicycle DIV_IP between two requesters,
// with a registered quotient on a valid/ready result port.
module div_ip_arbiter
    import div_arb_pkg::*;
#(
    parameter int IP_WIDTH    = DEF_IP_WIDTH,
    parameter int CALC_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid0,
    input  logic                  in_valid1,
    output logic                  in_ready0,
    output logic                  in_ready1,
    input  logic [IP_WIDTH*4-1:0] dividend0,
    input  logic [IP_WIDTH*4-1:0] dividend1,
    input  logic [IP_WIDTH*4-1:0] divisor0,
    input  logic [IP_WIDTH*4-1:0] divisor1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_id,
    output logic [IP_WIDTH*4-1:0] out_quotient,
    output logic                  out_dz
);

    localparam int W = IP_WIDTH * 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALC_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [W-1:0]     op_dividend_q, op_dividend_d;
    logic [W-1:0]     op_divisor_q, op_divisor_d;
    logic             op_id_q, op_id_d;
    logic             out_valid_q, out_valid_d;
    logic             out_id_q, out_id_d;
    logic [W-1:0]     out_quotient_q, out_quotient_d;
    logic             out_dz_q, out_dz_d;

    logic             grant;
    logic             xfer;
    logic [W-1:0]     div_quotient;

    div_ip #(.IP_WIDTH(IP_WIDTH)) u_div_ip (
        .dividend (op_dividend_q),
        .divisor  (op_divisor_q),
        .quotient (div_quotient)
    );

    // Ties alternate away from the previous winner; a lone requester always wins.
    assign grant     = (in_valid0 && in_valid1) ? ~last_grant_q : in_valid1;
    assign in_ready0 = (state_q == S_IDLE) && !grant;
    assign in_ready1 = (state_q == S_IDLE) && grant;
    assign xfer      = (in_valid0 && in_ready0) || (in_valid1 && in_ready1);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        op_dividend_d  = op_dividend_q;
        op_divisor_d   = op_divisor_q;
        op_id_d        = op_id_q;
        out_valid_d    = out_valid_q;
        out_id_d       = out_id_q;
        out_quotient_d = out_quotient_q;
        out_dz_d       = out_dz_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    op_dividend_d = grant ? dividend1 : dividend0;
                    op_divisor_d  = grant ? divisor1 : divisor0;
                    op_id_d       = grant;
                    last_grant_d  = grant;
                    cnt_d         = '0;
                    state_d       = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    out_dz_d       = (op_divisor_q == '0);
                    out_quotient_d = (op_divisor_q == '0) ? '1 : div_quotient;
                    out_id_d       = op_id_q;
                    out_valid_d    = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            last_grant_q   <= 1'b1;
            op_dividend_q  <= '0;
            op_divisor_q   <= '0;
            op_id_q        <= 1'b0;
            out_valid_q    <= 1'b0;
            out_id_q       <= 1'b0;
            out_quotient_q <= '0;
            out_dz_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            op_dividend_q  <= op_dividend_d;
            op_divisor_q   <= op_divisor_d;
            op_id_q        <= op_id_d;
            out_valid_q    <= out_valid_d;
            out_id_q       <= out_id_d;
            out_quotient_q <= out_quotient_d;
            out_dz_q       <= out_dz_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign out_quotient = out_quotient_q;
    assign out_dz       = out_dz_q;

endmodule

// File: tb/tb_div_ip_arbiter.sv
// Randomized scoreboard bench for div_ip_arbiter (main instance CALC_CYCLES=1, side instance CALC_CYCLES=3).
module tb_div_ip_arbiter;

    localparam int W  = 28;
    localparam int CC = 1;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         v0 = 1'b0, v1 = 1'b0, ordy = 1'b1;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         r0, r1, ov, oid, odz;
    logic [W-1:0] oq;

    logic         c3v0 = 1'b0;
    logic [W-1:0] c3a0 = '0, c3b0 = '0;
    logic         c3r0, c3r1, c3ov, c3oid, c3odz;
    logic [W-1:0] c3oq;

    always #5 clk = ~clk;

    div_ip_arbiter #(.IP_WIDTH(7), .CALC_CYCLES(CC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid0(v0), .in_valid1(v1), .in_ready0(r0), .in_ready1(r1),
        .dividend0(a0), .dividend1(a1), .divisor0(b0), .divisor1(b1),
        .out_valid(ov), .out_ready(ordy), .out_id(oid),
        .out_quotient(oq), .out_dz(odz)
    );

    div_ip_arbiter #(.IP_WIDTH(7), .CALC_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid0(c3v0), .in_valid1(1'b0), .in_ready0(c3r0), .in_ready1(c3r1),
        .dividend0(c3a0), .dividend1('0), .divisor0(c3b0), .divisor1('0),
        .out_valid(c3ov), .out_ready(1'b1), .out_id(c3oid),
        .out_quotient(c3oq), .out_dz(c3odz)
    );

    typedef struct {
        bit           id;
        logic [W-1:0] q;
        bit           dz;
        int           due;
        bit           seen;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   cycle = 0, prev_x = -1, c3_due = 0, c3_results = 0, timeouts = 0;
    bit   m_last = 1'b1, c3_pend = 1'b0, cont_mode = 1'b0;
    bit   final_req = 1'b0, done = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cycle);
        end
    endtask

    // Reference: one op in flight at a time; ties go to the requester that did not win last.
    always @(negedge clk) begin
        exp_t         e;
        bit           pid;
        logic [W-1:0] a, b;
        cycle++;
        if (!rst_n) begin
            exp_q.delete();
            m_last  = 1'b1;
            c3_pend = 1'b0;
            prev_x  = -1;
            chk("rst_out_valid", longint'(ov), 0);
            chk("rst_out_id", longint'(oid), 0);
            chk("rst_out_quotient", longint'(oq), 0);
            chk("rst_out_dz", longint'(odz), 0);
            chk("rst_c3_out_valid", longint'(c3ov), 0);
        end else begin
            if (exp_q.size() == 0) begin
                if (v0 || v1) begin
                    pid = (v0 && v1) ? !m_last : v1;
                    chk("grant", longint'({v1 && r1, v0 && r0}), pid ? 2 : 1);
                    if (cont_mode && prev_x >= 0) chk("issue_interval", cycle - prev_x, CC + 2);
                    prev_x = cont_mode ? cycle : -1;
                    a = pid ? a1 : a0;
                    b = pid ? b1 : b0;
                    e.id   = pid;
                    e.dz   = (b == 0);
                    e.q    = (b == 0) ? {W{1'b1}} : a / b;
                    e.due  = cycle + 1 + CC;
                    e.seen = 1'b0;
                    exp_q.push_back(e);
                    m_last = pid;
                end
            end else begin
                chk("ready_while_busy", longint'({r1, r0}), 0);
            end

            if (ov) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", longint'(ov), 0);
                end else begin
                    if (!exp_q[0].seen) begin
                        chk("latency", cycle, exp_q[0].due);
                        exp_q[0].seen = 1'b1;
                    end
                    chk("out_id", longint'(oid), longint'(exp_q[0].id));
                    chk("out_quotient", longint'(oq), longint'(exp_q[0].q));
                    chk("out_dz", longint'(odz), longint'(exp_q[0].dz));
                    if (ordy) void'(exp_q.pop_front());
                end
            end else if (exp_q.size() > 0 && cycle >= exp_q[0].due) begin
                chk("result_late", longint'(ov), 1);
            end

            if (c3v0 && c3r0) begin
                c3_pend = 1'b1;
                c3_due  = cycle + 1 + 3;
            end
            if (c3ov) begin
                chk("c3_expected", longint'(c3_pend), 1);
                chk("c3_latency", cycle, c3_due);
                chk("c3_quotient", longint'(c3oq), longint'(c3a0 / c3b0));
                c3_results++;
                c3_pend = 1'b0;
            end

            if (final_req && !done) begin
                chk("timeouts", timeouts, 0);
                chk("results_pending", exp_q.size(), 0);
                chk("c3_results", c3_results, 1);
                done = 1'b1;
            end
        end
    end

    task automatic tick(output bit h0, output bit h1);
        @(negedge clk);
        h0 = v0 && r0;
        h1 = v1 && r1;
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        bit h0, h1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !ov) return;
            tick(h0, h1);
        end
        timeouts++;
    endtask

    task automatic req1(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        bit h0, h1;
        if (id) begin a1 = a; b1 = b; v1 = 1'b1; end
        else    begin a0 = a; b0 = b; v0 = 1'b1; end
        for (int i = 0; i < 100; i++) begin
            tick(h0, h1);
            if ((id && h1) || (!id && h0)) begin
                if (id) v1 = 1'b0; else v0 = 1'b0;
                return;
            end
        end
        v0 = 1'b0; v1 = 1'b0;
        timeouts++;
    endtask

    task automatic both(input logic [W-1:0] x0, input logic [W-1:0] y0,
                        input logic [W-1:0] x1, input logic [W-1:0] y1);
        bit h0, h1;
        a0 = x0; b0 = y0; a1 = x1; b1 = y1; v0 = 1'b1; v1 = 1'b1;
        for (int i = 0; i < 100 && (v0 || v1); i++) begin
            tick(h0, h1);
            if (h0) v0 = 1'b0;
            if (h1) v1 = 1'b0;
        end
        if (v0 || v1) timeouts++;
        v0 = 1'b0; v1 = 1'b0;
    endtask

    function automatic logic [W-1:0] rnd_op(input bit allow_zero);
        int unsigned r = $urandom_range(0, 7);
        if (r == 0 && allow_zero) return '0;
        if (r <= 2) return W'($urandom_range(1, 15));
        return W'($urandom);
    endfunction

    initial begin
        bit h0, h1;
        int n;
        repeat (3) tick(h0, h1);
        rst_n = 1'b1;
        tick(h0, h1);

        both(28'd50, 28'd5, 28'd81, 28'd9);
        drain();
        req1(1'b0, 28'd100, 28'd7);
        drain();

        cont_mode = 1'b1;
        a0 = rnd_op(0); b0 = rnd_op(1); a1 = rnd_op(0); b1 = rnd_op(1);
        v0 = 1'b1; v1 = 1'b1; n = 0;
        for (int i = 0; i < 100 && n < 8; i++) begin
            tick(h0, h1);
            if (h0) begin n++; a0 = rnd_op(0); b0 = rnd_op(1); end
            if (h1) begin n++; a1 = rnd_op(0); b1 = rnd_op(1); end
        end
        if (n < 8) timeouts++;
        v0 = 1'b0; v1 = 1'b0;
        drain();
        cont_mode = 1'b0;

        req1(1'b1, 28'hFFFFFFF, 28'd0);
        drain();

        ordy = 1'b0;
        req1(1'b0, 28'd1000, 28'd3);
        for (int i = 0; i < 20 && !ov; i++) tick(h0, h1);
        a1 = 28'd81; b1 = 28'd9; v1 = 1'b1;
        repeat (5) tick(h0, h1);
        ordy = 1'b1;
        h1 = 1'b0;
        for (int i = 0; i < 50 && !h1; i++) tick(h0, h1);
        if (!h1) timeouts++;
        v1 = 1'b0;
        drain();

        for (int i = 0; i < 400; i++) begin
            tick(h0, h1);
            if (h0) v0 = 1'b0;
            if (h1) v1 = 1'b0;
            if (!v0 && $urandom_range(0, 2) == 0) begin a0 = rnd_op(0); b0 = rnd_op(1); v0 = 1'b1; end
            else if (v0 && $urandom_range(0, 39) == 0) v0 = 1'b0;
            if (!v1 && $urandom_range(0, 2) == 0) begin a1 = rnd_op(0); b1 = rnd_op(1); v1 = 1'b1; end
            else if (v1 && $urandom_range(0, 39) == 0) v1 = 1'b0;
            ordy = ($urandom_range(0, 3) != 0);
        end
        v0 = 1'b0; v1 = 1'b0; ordy = 1'b1;
        drain();

        req1(1'b0, 28'd100, 28'd7);
        rst_n = 1'b0;
        tick(h0, h1);
        rst_n = 1'b1;
        repeat (4) tick(h0, h1);
        both(28'd50, 28'd5, 28'd81, 28'd9);
        drain();

        c3a0 = 28'd100; c3b0 = 28'd7; c3v0 = 1'b1;
        tick(h0, h1);
        c3v0 = 1'b0;
        repeat (8) tick(h0, h1);

        final_req = 1'b1;
        for (int i = 0; i < 10 && !done; i++) tick(h0, h1);
        if (!done) begin
            $display("FAIL final_checks actual=not_run required=run");
            $fatal(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
